// File: rtl/param_sync_fifo_pkg.sv
// Shared defaults for the parametrised single-clock FIFO.
package param_sync_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH       = 32;
  localparam int unsigned DEF_FIFO_DEPTH       = 4;
  localparam int unsigned DEF_EARLY_FULL_SLACK = 1;
  localparam int unsigned DEF_FULL_PUSH_POP    = 0;

  // Occupancy counter width for a given depth (needs to hold DEPTH itself).
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Producer/consumer handshake bundle for param_sync_fifo.
interface param_sync_fifo_if
  import param_sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CNT_W      = cnt_width(DEF_FIFO_DEPTH)
);

  logic                  flush;
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  early_valid;
  logic                  full;
  logic                  early_full;
  logic [CNT_W-1:0]      count;

  // Side that drives requests and observes status.
  modport master (
    output flush, push, data_in, pop,
    input  data_out, valid, early_valid, full, early_full, count
  );

  // The FIFO itself.
  modport slave (
    input  flush, push, data_in, pop,
    output data_out, valid, early_valid, full, early_full, count
  );

endinterface

// File: rtl/fifo_ptr_counter.sv
// Wrapping pointer counter with async reset, increment and synchronous clear.
module fifo_ptr_counter #(
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_d;

  // Clear wins over increment; increment wraps naturally at 2**PTR_W.
  always_comb begin
    ptr_d = ptr;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr + PTR_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_d;
    end
  end

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised circular-buffer FIFO with flush, occupancy count and early-full.
module param_sync_fifo
  import param_sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH       = DEF_FIFO_DEPTH,
  parameter int unsigned EARLY_FULL_SLACK = DEF_EARLY_FULL_SLACK,
  parameter int unsigned FULL_PUSH_POP    = DEF_FULL_PUSH_POP
) (
  input logic               clk,
  input logic               rst,
  param_sync_fifo_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam bit          FPP_EN = (FULL_PUSH_POP != 0);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] EF_LVL   = CNT_W'(FIFO_DEPTH - EARLY_FULL_SLACK);

  // Reject illegal configurations at elaboration.
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("param_sync_fifo: DATA_WIDTH must be >= 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("param_sync_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (EARLY_FULL_SLACK < 1 || EARLY_FULL_SLACK > FIFO_DEPTH - 1) begin : g_bad_slack
    $error("param_sync_fifo: EARLY_FULL_SLACK must be in 1..FIFO_DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic                  valid_q;
  logic                  full_q;
  logic                  early_full_q;
  logic                  push_acc;
  logic                  pop_acc;

  // Request acceptance and next occupancy; flush overrides both requests.
  always_comb begin
    pop_acc  = bus.pop & valid_q & ~bus.flush;
    push_acc = bus.push & ~bus.flush & (~full_q | (FPP_EN & pop_acc));
    count_d  = count_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
    if (bus.flush) begin
      count_d = '0;
    end
  end

  // Occupancy and status flags, all derived from the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= '0;
      valid_q      <= 1'b0;
      full_q       <= 1'b0;
      early_full_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      valid_q      <= (count_d != '0);
      full_q       <= (count_d == FULL_LVL);
      early_full_q <= (count_d >= EF_LVL);
    end
  end

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  fifo_ptr_counter #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (bus.flush),
    .inc (pop_acc),
    .ptr (rd_ptr)
  );

  fifo_ptr_counter #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (bus.flush),
    .inc (push_acc),
    .ptr (wr_ptr)
  );

  // Head entry is read straight from storage; early_valid is held low in reset.
  assign bus.data_out    = mem[rd_ptr];
  assign bus.valid       = valid_q;
  assign bus.full        = full_q;
  assign bus.early_full  = early_full_q;
  assign bus.count       = count_q;
  assign bus.early_valid = ~rst & (count_d != '0);

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: one instance per FULL_PUSH_POP setting.
module tb_param_sync_fifo;

  localparam int unsigned DW = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned SL = 1;
  localparam int unsigned CW = 3;

  logic clk = 1'b0;
  logic rst;
  logic push, pop, flush;
  logic [DW-1:0] din;
  bit   chk_en;
  int   total = 0;
  int   bad   = 0;

  always #10 clk = ~clk;

  param_sync_fifo_if #(.DATA_WIDTH(DW), .CNT_W(CW)) b0 ();
  param_sync_fifo_if #(.DATA_WIDTH(DW), .CNT_W(CW)) b1 ();

  assign b0.push = push;  assign b0.pop = pop;  assign b0.flush = flush;  assign b0.data_in = din;
  assign b1.push = push;  assign b1.pop = pop;  assign b1.flush = flush;  assign b1.data_in = din;

  param_sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .EARLY_FULL_SLACK(SL), .FULL_PUSH_POP(0))
    u0 (.clk(clk), .rst(rst), .bus(b0));
  param_sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .EARLY_FULL_SLACK(SL), .FULL_PUSH_POP(1))
    u1 (.clk(clk), .rst(rst), .bus(b1));

  // Reference model: plain queues of accepted entries, q1 allows push-while-full with pop.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  function automatic int msize(int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [DW-1:0] mhead(int m);
    return (m == 0) ? q0[0] : q1[0];
  endfunction

  function automatic int mnext(int m, bit ps, bit pp, bit fl);
    int sz;
    bit po, pu;
    sz = msize(m);
    if (fl) return 0;
    po = pp && (sz > 0);
    pu = ps && ((sz < int'(D)) || (m == 1 && po));
    return sz + int'(pu) - int'(po);
  endfunction

  task automatic model_tick();
    for (int m = 0; m < 2; m++) begin
      int  sz;
      bit  po, pu;
      sz = msize(m);
      po = pop && (sz > 0);
      pu = push && ((sz < int'(D)) || (m == 1 && po));
      if (flush) begin
        if (m == 0) q0.delete(); else q1.delete();
      end else begin
        if (po) begin
          if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (pu) begin
          if (m == 0) q0.push_back(din); else q1.push_back(din);
        end
      end
    end
  endtask

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp(int m, logic v, logic ev, logic f, logic ef, logic [CW-1:0] c, logic [DW-1:0] d);
    int sz;
    int nx;
    sz = msize(m);
    nx = rst ? 0 : mnext(m, push, pop, flush);
    check($sformatf("m%0d valid", m),       64'(v),  64'(sz != 0));
    check($sformatf("m%0d count", m),       64'(c),  64'(sz));
    check($sformatf("m%0d full", m),        64'(f),  64'(sz == int'(D)));
    check($sformatf("m%0d early_full", m),  64'(ef), 64'(sz >= int'(D - SL)));
    check($sformatf("m%0d early_valid", m), 64'(ev), 64'(nx != 0));
    if (sz > 0) check($sformatf("m%0d data_out", m), 64'(d), 64'(mhead(m)));
  endtask

  // Every cycle, mid low phase: registered outputs against the model.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      cmp(0, b0.valid, b0.early_valid, b0.full, b0.early_full, b0.count, b0.data_out);
      cmp(1, b1.valid, b1.early_valid, b1.full, b1.early_full, b1.count, b1.data_out);
    end
  end

  task automatic drive(bit ps, bit pp, bit fl, logic [DW-1:0] d);
    @(negedge clk);
    push = ps; pop = pp; flush = fl; din = d;
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0;
  endtask

  task automatic step(bit ps, bit pp, bit fl, logic [DW-1:0] d);
    drive(ps, pp, fl, d);
    tick();
  endtask

  task automatic chk_zero(string tag);
    check({tag, " valid0"},  64'(b0.valid),      64'(0));
    check({tag, " count0"},  64'(b0.count),      64'(0));
    check({tag, " full0"},   64'(b0.full),       64'(0));
    check({tag, " efull0"},  64'(b0.early_full), 64'(0));
    check({tag, " valid1"},  64'(b1.valid),      64'(0));
    check({tag, " count1"},  64'(b1.count),      64'(0));
    check({tag, " full1"},   64'(b1.full),       64'(0));
    check({tag, " efull1"},  64'(b1.early_full), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] fill [4];
    int nxt;
    fill[0] = 32'hA; fill[1] = 32'hB; fill[2] = 32'hC; fill[3] = 32'hD;
    rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; din = '0; chk_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Fill to full, then drain in order.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, fill[i]);
      if (i == 2) begin
        check("fill3 count", 64'(b0.count), 64'(3));
        check("fill3 efull", 64'(b0.early_full), 64'(1));
        check("fill3 full",  64'(b0.full), 64'(0));
      end
    end
    check("fill4 full",  64'(b0.full), 64'(1));
    check("fill4 count", 64'(b0.count), 64'(4));
    for (int i = 0; i < 4; i++) begin
      check("drain order", 64'(b0.data_out), 64'(fill[i]));
      step(1'b0, 1'b1, 1'b0, '0);
    end
    check("drain valid", 64'(b0.valid), 64'(0));

    // Interleaved traffic of 0..9 across two pointer wraps.
    nxt = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, DW'(i));
    for (int i = 3; i < 10; i++) begin
      check("wrap order", 64'(b0.data_out), 64'(nxt)); nxt++;
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, DW'(i));
    end
    for (int i = 0; i < 3; i++) begin
      check("wrap order", 64'(b0.data_out), 64'(nxt)); nxt++;
      step(1'b0, 1'b1, 1'b0, '0);
    end
    check("wrap empty", 64'(b0.valid), 64'(0));

    // Push+pop while full: dropped in u0, accepted in u1.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, fill[i]);
    step(1'b1, 1'b1, 1'b0, 32'hE);
    check("fpp0 count", 64'(b0.count), 64'(3));
    check("fpp0 full",  64'(b0.full),  64'(0));
    check("fpp1 count", 64'(b1.count), 64'(4));
    check("fpp1 full",  64'(b1.full),  64'(1));
    for (int i = 1; i < 4; i++) begin
      check("fpp0 order", 64'(b0.data_out), 64'(fill[i]));
      check("fpp1 order", 64'(b1.data_out), 64'(fill[i]));
      step(1'b0, 1'b1, 1'b0, '0);
    end
    check("fpp0 empty", 64'(b0.valid), 64'(0));
    check("fpp1 last",  64'(b1.data_out), 64'(32'hE));
    step(1'b0, 1'b1, 1'b0, '0);
    check("fpp1 empty", 64'(b1.valid), 64'(0));

    // Empty with push+pop: pop ignored, push lands.
    drive(1'b1, 1'b1, 1'b0, 32'h55);
    #3;
    check("ep early_valid0", 64'(b0.early_valid), 64'(1));
    check("ep early_valid1", 64'(b1.early_valid), 64'(1));
    tick();
    check("ep valid", 64'(b0.valid), 64'(1));
    check("ep data",  64'(b0.data_out), 64'(32'h55));
    check("ep count", 64'(b1.count), 64'(1));
    step(1'b0, 1'b1, 1'b0, '0);

    // Flush with push+pop at count 3.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, fill[i]);
    drive(1'b1, 1'b1, 1'b1, 32'h77);
    #3;
    check("fl early_valid0", 64'(b0.early_valid), 64'(0));
    check("fl early_valid1", 64'(b1.early_valid), 64'(0));
    tick();
    chk_zero("flush");
    step(1'b1, 1'b0, 1'b0, 32'h99);
    check("post flush data", 64'(b0.data_out), 64'(32'h99));
    check("post flush data1", 64'(b1.data_out), 64'(32'h99));
    step(1'b1, 1'b0, 1'b0, 32'h9A);
    check("pre rst count", 64'(b0.count), 64'(2));

    // Asynchronous reset in the middle of the high phase.
    #2;
    rst = 1'b1;
    q0.delete(); q1.delete();
    #1;
    chk_zero("async rst");
    @(negedge clk);
    #3;
    push = 1'b1; din = 32'h33;
    #1;
    check("rst early_valid", 64'(b0.early_valid), 64'(0));
    #1;
    rst = 1'b0;
    #1;
    check("rel early_valid", 64'(b0.early_valid), 64'(1));
    check("rel early_valid1", 64'(b1.early_valid), 64'(1));
    tick();
    check("rel count", 64'(b0.count), 64'(1));
    check("rel data",  64'(b0.data_out), 64'(32'h33));
    step(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    #3;
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
